// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for alu_seq_exec: an operation request channel and a
// result channel, each with its own valid/ready handshake.
interface alu_seq_exec_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         ovf;
   logic         illegal;

   modport master (
      output in_valid, alu_op, a, b, out_ready,
      input  in_ready, out_valid, result, zero, ovf, illegal
   );

   modport slave (
      input  in_valid, alu_op, a, b, out_ready,
      output in_ready, out_valid, result, zero, ovf, illegal
   );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle simple ops, W-step iterative MULU and optional
// restoring DIVU (built only when ALU_SEQ_DIV_EN is defined).
module alu_seq_exec #(
   parameter int W   = 32,
   parameter int SHW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_exec_if.slave bus
);
   localparam int CW = SHW + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [3:0] {
      OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
      OP_NOR  = 4'b0100, OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_SLTU = 4'b1000,
      OP_SLL  = 4'b1001, OP_SRL  = 4'b1010, OP_SRA  = 4'b1011, OP_LUI  = 4'b1100,
      OP_MULU = 4'b1101, OP_DIVU = 4'b1110
   } op_t;

   state_t       state;
   logic [CW-1:0] cnt;
   logic [W-1:0] acc;
   logic [W-1:0] opa;
   logic [W-1:0] opb;

   logic [W-1:0] sum, dif, simple_res, acc_add, iter_res;
   logic         simple_ovf, simple_ill, iter_op;
   logic [SHW-1:0] sh;

`ifdef ALU_SEQ_DIV_EN
   logic         div_op;
   logic [W:0]   rem_shift;
   logic         rem_ge;
   logic [W-1:0] rem_dif, quo_nxt;
`endif

   always_comb begin
      sum        = bus.a + bus.b;
      dif        = bus.a - bus.b;
      sh         = bus.a[SHW-1:0];
      simple_res = '0;
      simple_ovf = 1'b0;
      simple_ill = 1'b0;
      iter_op    = 1'b0;
      case (bus.alu_op)
         OP_AND:  simple_res = bus.a & bus.b;
         OP_OR:   simple_res = bus.a | bus.b;
         OP_ADD: begin
            simple_res = sum;
            simple_ovf = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
         end
         OP_XOR:  simple_res = bus.a ^ bus.b;
         OP_NOR:  simple_res = ~(bus.a | bus.b);
         OP_SUB: begin
            simple_res = dif;
            simple_ovf = (bus.a[W-1] != bus.b[W-1]) && (dif[W-1] != bus.a[W-1]);
         end
         OP_SLT:  simple_res = {{(W-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLTU: simple_res = {{(W-1){1'b0}}, bus.a < bus.b};
         OP_SLL:  simple_res = bus.b << sh;
         OP_SRL:  simple_res = bus.b >> sh;
         OP_SRA:  simple_res = W'($signed(bus.b) >>> sh);
         OP_LUI:  simple_res = {bus.b[W/2-1:0], {(W/2){1'b0}}};
         OP_MULU: iter_op = 1'b1;
`ifdef ALU_SEQ_DIV_EN
         OP_DIVU: iter_op = 1'b1;
`endif
         default: simple_ill = 1'b1;
      endcase
   end

   // Multiply: opa is the left-shifting multiplicand, opb the right-shifting
   // multiplier. Divide reuses opa as dividend-in/quotient-out and acc as remainder.
   always_comb begin
      acc_add = opb[0] ? acc + opa : acc;
      iter_res = acc_add;
`ifdef ALU_SEQ_DIV_EN
      rem_shift = {acc, opa[W-1]};
      rem_ge    = rem_shift >= {1'b0, opb};
      rem_dif   = rem_shift[W-1:0] - opb;
      quo_nxt   = {opa[W-2:0], rem_ge};
      if (div_op) iter_res = quo_nxt;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         acc           <= '0;
         opa           <= '0;
         opb           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.zero      <= 1'b0;
         bus.ovf       <= 1'b0;
         bus.illegal   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_op        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  opa          <= bus.a;
                  opb          <= bus.b;
                  bus.in_ready <= 1'b0;
                  if (iter_op) begin
                     state <= BUSY;
                     cnt   <= CW'(W);
                     acc   <= '0;
`ifdef ALU_SEQ_DIV_EN
                     div_op <= (bus.alu_op == OP_DIVU);
`endif
                  end else begin
                     state         <= DONE;
                     bus.out_valid <= 1'b1;
                     bus.result    <= simple_res;
                     bus.zero      <= (simple_res == '0);
                     bus.ovf       <= simple_ovf;
                     bus.illegal   <= simple_ill;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_DIV_EN
               if (div_op) begin
                  acc <= rem_ge ? rem_dif : rem_shift[W-1:0];
                  opa <= quo_nxt;
               end else
`endif
               begin
                  acc <= acc_add;
                  opa <= opa << 1;
                  opb <= opb >> 1;
               end
               // Last step retires straight into DONE so latency is W+1 edges.
               if (cnt == CW'(1)) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.result    <= iter_res;
                  bus.zero      <= (iter_res == '0);
                  bus.ovf       <= 1'b0;
                  bus.illegal   <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution-side consumer of the 4-bit ALUop code produced by the control decode path.
- Takes a decoded ALU operation plus two operands over a valid/ready handshake and returns the result over a second valid/ready handshake.
- Simple ops complete in one cycle. Multiply (and optionally divide) run iteratively, one bit per cycle.
- Sits between register-read and writeback in the multi-cycle datapath variant of the CPU.

Parameters:
- W, 32, operand/result width in bits (≥8, power of 2).
- SHW, 5, shift-amount width; must equal log2(W).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- alu_op  input  4  operation code (encoding below).
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  operation result.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow (ADD/SUB only, else 0).
- illegal  output  1  unsupported alu_op code.

Behaviour:
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed), 1000 SLTU.
  - 1001 SLL b by a[SHW-1:0], 1010 SRL, 1011 SRA.
  - 1100 LUI: b[W/2-1:0] placed in the upper half, lower half zero.
  - 1101 MULU: low W bits of the unsigned product.
  - 1110 DIVU: unsigned quotient a/b.
  - 0101 and 1111: illegal.
- Reset (async, rst_n=0):
  - State IDLE; in_ready=1; out_valid=0; result=0; zero=0; ovf=0; illegal=0.
  - Internal counter, accumulator and operand registers cleared.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch alu_op/a/b.
    - Simple or illegal op: go to DONE; result registered in the same edge (latency 1 cycle).
    - MULU/DIVU: go to BUSY with iteration count = W.
  - BUSY: in_ready=0. One shift-add (MULU) or restoring subtract (DIVU) step per cycle. After exactly W steps go to DONE, so request-to-out_valid latency is W+1 cycles.
  - DONE: out_valid=1; result, zero, ovf and illegal held stable until out_ready=1. On the handshake edge go to IDLE; out_valid drops the next cycle.
  - in_ready is high only in IDLE, so peak throughput is one op per 2 cycles.
- in_valid while in_ready=0 is ignored. The source must hold the request.
- ovf:
  - ADD: a and b have the same sign and the result sign differs.
  - SUB: a and b have different signs and the result sign differs from a.
- SLT/SLTU return 1 or 0 in bit 0, other bits zero.
- Shift amount uses only a[SHW-1:0]; upper bits of a are ignored.
- DIVU with b==0: result = all ones, illegal=0, latency still W+1.
- illegal op: result=0, zero=1, illegal=1.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately with no output. The pending result is lost.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: DIVU (1110) is implemented as described.
- Undefined: no divider logic is built. 1110 is treated as illegal: latency 1, result=0, zero=1, illegal=1.

Test Plan:
- Reset release, then ADD a=0x7FFFFFFF b=0x00000001 -> out_valid 1 cycle after accept, result=0x80000000, ovf=1, zero=0.
- SUB a=5 b=5, with out_ready held 0 for 3 cycles -> result=0, zero=1; out_valid and result stable all 3 cycles; in_ready=0 until the handshake.
- SRA b=0x80000000 a=0x00000024 (amount 4) -> result=0xF8000000. SLT a=0xFFFFFFFF b=1 -> result=1. SLTU with the same operands -> result=0.
- MULU a=0x00010003 b=0x00000007 -> out_valid exactly 33 cycles after accept, result=0x00070015. in_valid pulses during BUSY are ignored.
- With ALU_SEQ_DIV_EN: DIVU a=100 b=7 -> result=14 at 33 cycles; DIVU b=0 -> result=0xFFFFFFFF. Without the macro: DIVU -> illegal=1, result=0, at 1 cycle.
- Assert rst_n=0 at cycle 10 of a MULU -> out_valid stays 0, in_ready=1 after release, and the next ADD 2+3 returns 5.
